uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART TX FIFO write port between up to NUM_SRC byte-stream producers (timer reporter, status monitors, command echo). Each producer presents bytes on a valid/ready interface with a last flag. The arbiter grants one producer at a time and holds the grant for a whole packet, so packets from different sources never interleave in the UART byte stream. It drives the FIFO's clock, write request and data directly and respects FIFO back-pressure.

## Interface
- NUM_SRC, 4: number of requesters; legal range 2..8.
- MAX_PKT_LEN, 16: maximum bytes per grant; legal range 1..255. A packet reaching this count without last is force-terminated.
- clk_50m  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_data  in  8*NUM_SRC  source i byte on [8i+7:8i].
- src_last  in  NUM_SRC  per-source final byte of packet; qualified by valid.
- src_ready  out  NUM_SRC  per-source byte accepted when valid&ready.
- fifo_full  in  1  FIFO almost-full flag; must assert while ≤1 free entry remains.
- uart_tx_fifo_clk  out  1  equals clk_50m.
- uart_tx_fifo_req  out  1  FIFO write enable; one byte per high cycle.
- uart_tx_fifo_data  out  8  FIFO write data.
- grant_id  out  3  index of the current or most recent granted source.
- busy  out  1  high in XFER.
- trunc_err  out  1  one-cycle pulse when a packet is cut at MAX_PKT_LEN.

## Operation
- FSM states: IDLE, XFER.
- IDLE:
  - Search src_valid round-robin, starting at (last_grant+1) mod NUM_SRC.
  - On any hit, register grant_id = winner, clear byte_cnt and move to XFER.
  - No hit: stay in IDLE.
- XFER:
  - src_ready[grant_id] = ~fifo_full. All other src_ready bits are 0.
  - Accept = src_valid[grant_id] & src_ready[grant_id].
  - On accept: uart_tx_fifo_req<=1, uart_tx_fifo_data<=source byte, byte_cnt<=byte_cnt+1 (8-bit).
  - No accept: uart_tx_fifo_req<=0 and data holds its last value.
- Leaving XFER:
  - Accept with src_last: go to IDLE and set last_grant<=grant_id.
  - Accept with byte_cnt+1==MAX_PKT_LEN and no last: pulse trunc_err, go to IDLE, set last_grant<=grant_id. The source's remaining bytes form a new packet at its next grant.
  - last and MAX coinciding: normal end; no trunc_err.
- Source drops valid mid-packet: grant is held indefinitely and bytes resume when valid returns. There is no timeout.
- src_last on a non-granted source is ignored.
- src_ready is 0 for every source in IDLE.
- Reset values:
  - state=IDLE, last_grant=NUM_SRC-1 (source 0 has first priority), byte_cnt=0.
  - src_ready=0, uart_tx_fifo_req=0, uart_tx_fifo_data=0, grant_id=0, busy=0, trunc_err=0.

## Timing
- Request latency: src_valid seen in IDLE at edge k puts the FSM in XFER after edge k. src_ready is high in cycle k+1, the first byte is accepted at edge k+1, and req is high during cycle k+2.
- Write latency: a byte accepted at edge n appears on req/data in the cycle after edge n, for exactly one cycle.
- Throughput: one byte per cycle while the source stays valid and fifo_full stays low. An L-byte packet gives L consecutive req cycles.
- Packet gap: at least one IDLE cycle between packets, so back-to-back packets cost L+1 cycles each.
- fifo_full is sampled combinationally into src_ready. Because the write is registered, one byte can already be in flight when full rises; this is why fifo_full must be an almost-full flag.
- Simultaneous requests in IDLE: the lowest index at or after last_grant+1, wrapping, wins. After finishing, a source cannot win again while any other source is requesting.
- Reset mid-packet: the next cycle shows reset values, with no partial write and no pulse. The source must restart its packet.

## Test plan
- Single packet: reset, then src_valid[2] with bytes 0x12, 0x34 (last on 0x34). Required: req high 2 consecutive cycles with data 0x12 then 0x34, the first req 2 cycles after valid. grant_id=2, busy drops after the last accept.
- Round robin: all 4 sources continuously send 1-byte packets with data = 0xA0+i. Required: FIFO sequence A0, A1, A2, A3, A0…, with one idle cycle between writes.
- Back-pressure: during a 4-byte packet from source 1, assert fifo_full for 3 cycles after byte 2. Required: src_ready[1]=0 for those cycles, no req, then bytes 3 and 4 written in order with no loss or duplication.
- Truncation: MAX_PKT_LEN=4; source 0 sends 6 bytes 0x01..0x06 with last on 0x06 while source 3 is requesting. Required: writes 01-04, trunc_err pulse on the 4th accept, then source 3's packet, then 05, 06.
- Stall and non-interleave: source 0 drops valid for 5 cycles mid-packet while source 1 is valid. Required: src_ready[1] stays 0 and source 0's packet completes before any source 1 byte.
- Reset mid-packet: assert reset after byte 1 of a 3-byte packet. Required: all outputs at reset values the next cycle, and a subsequent request from source 3 gets priority after source 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX FIFO write port between byte producers.
// A grant is held for a whole packet (or MAX_PKT_LEN bytes) so packets never interleave.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic                   clk_50m,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_ready,
  input  logic                   fifo_full,
  output logic                   uart_tx_fifo_clk,
  output logic                   uart_tx_fifo_req,
  output logic [7:0]             uart_tx_fifo_data,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   trunc_err
);

  typedef enum logic {StIdle, StXfer} state_t;

  state_t     state_q, state_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic [2:0] grant_q, grant_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       req_q, req_d;
  logic [7:0] data_q, data_d;
  logic       trunc_q, trunc_d;

  logic       hi_found;
  logic [2:0] hi_idx, lo_idx, win_idx;
  logic       sel_valid, sel_last, accept, at_max;
  logic [7:0] sel_data, cnt_inc;

  // Rotating priority: lowest requester above last_grant, else wrap to lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        lo_idx = 3'(i);
        if (3'(i) > last_grant_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    src_ready = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid    = src_valid[i];
        sel_last     = src_last[i];
        sel_data     = src_data[8*i +: 8];
        src_ready[i] = (state_q == StXfer) && !fifo_full;
      end
    end
  end

  assign accept  = (state_q == StXfer) && sel_valid && !fifo_full;
  assign cnt_inc = byte_cnt_q + 8'd1;
  assign at_max  = (cnt_inc == 8'(MAX_PKT_LEN));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    byte_cnt_d   = byte_cnt_q;
    req_d        = 1'b0;
    data_d       = data_q;
    trunc_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (|src_valid) begin
          grant_d    = win_idx;
          byte_cnt_d = '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (accept) begin
          req_d      = 1'b1;
          data_d     = sel_data;
          byte_cnt_d = cnt_inc;
          if (sel_last) begin
            state_d      = StIdle;
            last_grant_d = grant_q;
          end else if (at_max) begin
            trunc_d      = 1'b1;
            state_d      = StIdle;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 3'(NUM_SRC - 1);
      grant_q      <= '0;
      byte_cnt_q   <= '0;
      req_q        <= 1'b0;
      data_q       <= '0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      byte_cnt_q   <= byte_cnt_d;
      req_q        <= req_d;
      data_q       <= data_d;
      trunc_q      <= trunc_d;
    end
  end

  assign uart_tx_fifo_clk  = clk_50m;
  assign uart_tx_fifo_req  = req_q;
  assign uart_tx_fifo_data = data_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q == StXfer);
  assign trunc_err         = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: tests push expected FIFO writes, a monitor pops them.
module tb_uart_tx_arbiter;
  localparam int NUM_SRC = 4;
  localparam int MAX_LEN = 4;

  logic                 clk_50m;
  logic                 reset;
  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 fifo_full;
  logic                 uart_tx_fifo_clk;
  logic                 uart_tx_fifo_req;
  logic [7:0]           uart_tx_fifo_data;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 trunc_err;

  uart_tx_arbiter #(.NUM_SRC(NUM_SRC), .MAX_PKT_LEN(MAX_LEN)) dut (
    .clk_50m           (clk_50m),
    .reset             (reset),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .src_last          (src_last),
    .src_ready         (src_ready),
    .fifo_full         (fifo_full),
    .uart_tx_fifo_clk  (uart_tx_fifo_clk),
    .uart_tx_fifo_req  (uart_tx_fifo_req),
    .uart_tx_fifo_data (uart_tx_fifo_data),
    .grant_id          (grant_id),
    .busy              (busy),
    .trunc_err         (trunc_err)
  );

  // Per-source byte streams {last, data}; expected writes {trunc, data}.
  logic [8:0]         sq [NUM_SRC][$];
  logic [8:0]         exp_q [$];
  int                 wr_cyc [$];
  logic [NUM_SRC-1:0] hold;
  int                 cyc;
  int                 checks;
  int                 fails;

  initial begin
    clk_50m = 1'b0;
    forever #5 clk_50m = ~clk_50m;
  end

  initial cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] d, input logic l);
    sq[s].push_back({l, d});
  endtask

  task automatic expect_wr(input logic [7:0] d, input logic t);
    exp_q.push_back({t, d});
  endtask

  // Source drivers: pop a byte once it was accepted, present the next one after the edge.
  initial begin
    logic [NUM_SRC-1:0] acc;
    logic [8:0]         f;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    forever begin
      @(negedge clk_50m);
      acc = src_valid & src_ready & {NUM_SRC{~reset}};
      @(posedge clk_50m);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        if (sq[i].size() > 0 && !hold[i]) begin
          f = sq[i][0];
          src_valid[i]        = 1'b1;
          src_last[i]         = f[8];
          src_data[8*i +: 8]  = f[7:0];
        end else begin
          src_valid[i]        = 1'b0;
          src_last[i]         = 1'b0;
          src_data[8*i +: 8]  = 8'h00;
        end
      end
    end
  end

  // Monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clk_50m) begin
    logic [8:0] e;
    if (uart_tx_fifo_req) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(uart_tx_fifo_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", 32'(uart_tx_fifo_data), 32'(e[7:0]));
        chk("wr_trunc", 32'(trunc_err), 32'(e[8]));
      end
    end else if (trunc_err) begin
      chk("trunc_without_write", 32'(trunc_err), 32'h0);
    end
  end

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) if (sq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || src_pending() || busy) && n < 200) begin
      @(negedge clk_50m);
      n++;
    end
    chk({name, "_drain"}, 32'(n < 200), 32'h1);
    repeat (3) @(negedge clk_50m);
    chk({name, "_leftover"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic flush_srcs();
    for (int i = 0; i < NUM_SRC; i++) sq[i].delete();
    hold = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_50m);
    reset     = 1'b1;
    fifo_full = 1'b0;
    flush_srcs();
    repeat (2) @(negedge clk_50m);
    reset = 1'b0;
  endtask

  initial begin
    int p;
    checks    = 0;
    fails     = 0;
    reset     = 1'b1;
    fifo_full = 1'b0;
    hold      = '0;

    // Reset state
    repeat (3) @(negedge clk_50m);
    chk("rst_ready", 32'(src_ready), 32'h0);
    chk("rst_req", 32'(uart_tx_fifo_req), 32'h0);
    chk("rst_data", 32'(uart_tx_fifo_data), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_trunc", 32'(trunc_err), 32'h0);
    reset = 1'b0;

    // Single packet from source 2: first write three cycles after the push
    @(negedge clk_50m);
    wr_cyc.delete();
    p = cyc;
    push_byte(2, 8'h12, 1'b0);
    push_byte(2, 8'h34, 1'b1);
    expect_wr(8'h12, 1'b0);
    expect_wr(8'h34, 1'b0);
    repeat (3) @(negedge clk_50m);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_grant", 32'(grant_id), 32'h2);
    @(negedge clk_50m);
    chk("single_busy_drop", 32'(busy), 32'h0);
    chk("single_grant_hold", 32'(grant_id), 32'h2);
    wait_done("single");
    chk("single_nwr", 32'(wr_cyc.size()), 32'h2);
    if (wr_cyc.size() >= 2) begin
      chk("single_lat", 32'(wr_cyc[0] - p), 32'h3);
      chk("single_consec", 32'(wr_cyc[1] - wr_cyc[0]), 32'h1);
    end

    // Round robin of 1-byte packets from all sources
    do_reset();
    wr_cyc.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_SRC; i++) begin
        push_byte(i, 8'(8'hA0 + i), 1'b1);
        expect_wr(8'(8'hA0 + i), 1'b0);
      end
    wait_done("rr");
    chk("rr_nwr", 32'(wr_cyc.size()), 32'h8);
    if (wr_cyc.size() == 8)
      for (int k = 1; k < 8; k++) chk("rr_gap", 32'(wr_cyc[k] - wr_cyc[k-1]), 32'h2);

    // Back-pressure: fifo_full for 3 cycles after byte 2 of a 4-byte packet
    @(negedge clk_50m);
    push_byte(1, 8'h10, 1'b0);
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h12, 1'b0);
    push_byte(1, 8'h13, 1'b1);
    for (int i = 0; i < 4; i++) expect_wr(8'(8'h10 + i), 1'b0);
    repeat (4) @(posedge clk_50m);
    #1 fifo_full = 1'b1;
    @(negedge clk_50m);
    chk("bp_ready0", 32'(src_ready), 32'h0);
    chk("bp_inflight", 32'(uart_tx_fifo_req), 32'h1);
    @(negedge clk_50m);
    chk("bp_ready1", 32'(src_ready), 32'h0);
    chk("bp_noreq1", 32'(uart_tx_fifo_req), 32'h0);
    @(negedge clk_50m);
    chk("bp_ready2", 32'(src_ready), 32'h0);
    chk("bp_noreq2", 32'(uart_tx_fifo_req), 32'h0);
    chk("bp_data_hold", 32'(uart_tx_fifo_data), 32'h11);
    @(posedge clk_50m);
    #1 fifo_full = 1'b0;
    @(negedge clk_50m);
    chk("bp_ready_back", 32'(src_ready), 32'h2);
    wait_done("bp");

    // Truncation at 4 bytes while source 3 is requesting
    do_reset();
    for (int i = 1; i <= 6; i++) push_byte(0, 8'(i), 1'(i == 6));
    push_byte(3, 8'h33, 1'b1);
    expect_wr(8'h01, 1'b0);
    expect_wr(8'h02, 1'b0);
    expect_wr(8'h03, 1'b0);
    expect_wr(8'h04, 1'b1);
    expect_wr(8'h33, 1'b0);
    expect_wr(8'h05, 1'b0);
    expect_wr(8'h06, 1'b0);
    wait_done("trunc");

    // Source 0 stalls mid-packet; source 1 must wait
    do_reset();
    push_byte(0, 8'h50, 1'b0);
    push_byte(0, 8'h51, 1'b0);
    push_byte(0, 8'h52, 1'b1);
    push_byte(1, 8'h60, 1'b1);
    expect_wr(8'h50, 1'b0);
    expect_wr(8'h51, 1'b0);
    expect_wr(8'h52, 1'b0);
    expect_wr(8'h60, 1'b0);
    repeat (2) @(negedge clk_50m);
    hold[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_50m);
      chk("stall_ready1", 32'(src_ready[1]), 32'h0);
      chk("stall_grant", 32'(grant_id), 32'h0);
    end
    hold[0] = 1'b0;
    wait_done("stall");

    // Reset after byte 1 of a 3-byte packet, then priority restarts at source 0
    @(negedge clk_50m);
    push_byte(0, 8'h70, 1'b0);
    push_byte(0, 8'h71, 1'b0);
    push_byte(0, 8'h72, 1'b1);
    expect_wr(8'h70, 1'b0);
    repeat (3) @(negedge clk_50m);
    reset = 1'b1;
    flush_srcs();
    @(negedge clk_50m);
    chk("mrst_ready", 32'(src_ready), 32'h0);
    chk("mrst_req", 32'(uart_tx_fifo_req), 32'h0);
    chk("mrst_data", 32'(uart_tx_fifo_data), 32'h0);
    chk("mrst_grant", 32'(grant_id), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_trunc", 32'(trunc_err), 32'h0);
    reset = 1'b0;
    push_byte(3, 8'h80, 1'b1);
    push_byte(0, 8'h90, 1'b1);
    expect_wr(8'h90, 1'b0);
    expect_wr(8'h80, 1'b0);
    wait_done("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
